mojo_top: RTL and testbench
===========================

Name: mojo_top

Overview:
- Top level of the Mojo-board basic CPU demonstrator.
- Executes one 8-bit instruction, taken from the trainer DIP switches, repeatedly through a 4-state fetch/decode/execute/writeback loop.
- Operates on a 4-entry x 8-bit register file.
- Drives the most recent writeback result onto the 8 board LEDs.

Parameters:
- DATA_W, 8, register/ALU/LED width.
- NREGS, 4, register file depth; 2-bit register indices.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; on the board it is wired to the activate push-button.
- trainer_dip  input  8  instruction word: [7:4] opcode, [3:2] rd, [1:0] rs/imm2.
- led  output  8  last written result value.

Behaviour:
Reset
- While rst=1: state=FETCH, ir=0x00, led=0x00.
- Register file reset values: R0=0x00, R1=0x01, R2=0x02, R3=0x03.
- Reset is asynchronous and may occur in any state; operation restarts at FETCH on the first rising edge after rst deasserts.

FSM: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH (one instruction per 4 clocks, no stalls).
- FETCH: ir <= trainer_dip. DIP changes in any other state are ignored until the next FETCH.
- DECODE: latch opA=R[rd], opB=R[rs], opcode.
- EXECUTE: result <= ALU(opcode, opA, opB, imm2). Combinational ALU, registered result.
- WRITEBACK: for writing opcodes, R[rd] <= result and led <= result. For non-writing opcodes, registers and led are unchanged.

Opcodes (8-bit arithmetic, wraps mod 256, no flags exported):
- 0x0 NOP (no write)
- 0x1 ADD rd=rd+rs
- 0x2 SUB rd=rd-rs
- 0x3 AND
- 0x4 OR
- 0x5 XOR
- 0x6 MOV rd=rs
- 0x7 NOT rd=~rs
- 0x8 SHL rd=rd<<1 (LSB 0)
- 0x9 SHR rd=rd>>1 (MSB 0)
- 0xA INC rd=rd+1
- 0xB DEC rd=rd-1
- 0xC LDI rd={6'b0,imm2}
- 0xD CLR rd=0
- 0xE, 0xF reserved, behave as NOP

Boundary rules:
- rd==rs is legal and uses the pre-instruction value (e.g. ADD R2,R2 doubles R2).
- Overflow wraps: 0xFF+1=0x00; 0x00-1=0xFF.
- A constant DIP value re-executes every 4 cycles, so ADD accumulates.

Decomposition:
- Package mojo_cpu_pkg: opcode localparams, FSM state encoding (FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3), register reset values, writes_rd() helper.
- One sub-module, cpu_alu: combinational; inputs opcode, a, b, imm2; output result[7:0].
- Register file, FSM and LED register stay in mojo_top.

Test Plan:
- Reset then dip=0x1E (ADD R3<-R2) held -> led=0x00 until first WRITEBACK. led=0x05 at the 4th rising edge after rst release, 0x07 at the 8th, 0x09 at the 12th.
- dip=0x63 (MOV R0<-R3) after reset -> led=0x03. Then dip=0x21 (SUB R0<-R1) -> led=0x02, then 0x01, 0x00, 0xFF (wrap).
- dip=0xC6 (LDI R1,2) -> led=0x02. Then dip=0x85 (SHL R1) -> led=0x04, 0x08, ..., 0x80, 0x00.
- dip=0x00 (NOP), or 0xF0 after a prior write -> led keeps its previous value, registers unchanged.
- DIP toggled in DECODE/EXECUTE -> executed instruction is the value sampled at FETCH.
- Assert rst during EXECUTE of 0x1E after R3=0x07 -> led=0x00 immediately (async), without a clock edge. After release, first result is 0x05 (registers re-initialised).

Source files
------------

// File: rtl/mojo_cpu_pkg.sv
// mojo_cpu_pkg
//   Shared definitions for the Mojo basic CPU demonstrator:
//   opcode encodings, FSM state encoding, register-file reset
//   values and the writes_rd() helper that tells whether an
//   opcode updates its destination register.
package mojo_cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_INC = 4'hA;
    localparam logic [3:0] OP_DEC = 4'hB;
    localparam logic [3:0] OP_LDI = 4'hC;
    localparam logic [3:0] OP_CLR = 4'hD;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    // Register Rn resets to the value n.
    function automatic logic [7:0] reg_rst_val(input int idx);
        return 8'(idx);
    endfunction

    // ADD..CLR write rd; NOP and the reserved 0xE/0xF do not.
    function automatic logic writes_rd(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_CLR);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu
//   Purely combinational ALU for the Mojo CPU. All arithmetic
//   wraps modulo 2**DATA_W; no flags are produced.
// Ports:
//   opcode  in  4        operation select
//   a       in  DATA_W   operand from R[rd]
//   b       in  DATA_W   operand from R[rs]
//   imm2    in  2        immediate for LDI
//   result  out DATA_W   operation result
module cpu_alu
    import mojo_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        imm2,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = a;
        case (opcode)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOV:  result = b;
            OP_NOT:  result = ~b;
            OP_SHL:  result = {a[DATA_W-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[DATA_W-1:1]};
            OP_INC:  result = a + DATA_W'(1);
            OP_DEC:  result = a - DATA_W'(1);
            OP_LDI:  result = {{(DATA_W-2){1'b0}}, imm2};
            OP_CLR:  result = '0;
            // NOP and reserved opcodes never write, value is don't-care
            default: result = a;
        endcase
    end

endmodule

// File: rtl/mojo_top.sv
// mojo_top
//   Mojo-board basic CPU demonstrator. Repeatedly executes the
//   instruction on the trainer DIP switches through a four-state
//   FETCH/DECODE/EXECUTE/WRITEBACK loop over a 4 x 8-bit register
//   file, showing the latest written result on the LEDs.
// Ports:
//   clk          in   1  system clock, rising-edge
//   rst          in   1  asynchronous active-high reset
//   trainer_dip  in   8  instruction: [7:4] opcode, [3:2] rd, [1:0] rs/imm2
//   led          out  8  last writeback result
module mojo_top
    import mojo_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        trainer_dip,
    output logic [DATA_W-1:0] led
);

    state_t            state_q, state_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];

    // Datapath latches: only consumed after being loaded in the
    // current instruction, so they carry no reset.
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [DATA_W-1:0] alu_result;
    logic [1:0]        rd_idx;
    logic [1:0]        rs_idx;

    assign rd_idx = ir_q[3:2];
    assign rs_idx = ir_q[1:0];
    assign led    = led_q;

    // imm2 comes straight from ir, which is stable from FETCH onward.
    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (op_q),
        .a      (opa_q),
        .b      (opb_q),
        .imm2   (ir_q[1:0]),
        .result (alu_result)
    );

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        led_d    = led_q;
        rf_d     = rf_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;

        case (state_q)
            ST_FETCH: begin
                ir_d    = trainer_dip;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // Both operands are read before any write, so rd==rs
                // sees the pre-instruction value.
                op_d    = ir_q[7:4];
                opa_d   = rf_q[rd_idx];
                opb_d   = rf_q[rs_idx];
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                result_d = alu_result;
                state_d  = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                if (writes_rd(op_q)) begin
                    rf_d[rd_idx] = result_q;
                    led_d        = result_q;
                end
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ir_q    <= 8'h00;
            led_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= DATA_W'(reg_rst_val(i));
            end
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            led_q   <= led_d;
            rf_q    <= rf_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q     <= op_d;
        opa_q    <= opa_d;
        opb_q    <= opb_d;
        result_q <= result_d;
    end

endmodule

// File: tb/tb_mojo_top.sv
module tb_mojo_top;

    logic       clk;
    logic       rst;
    logic [7:0] trainer_dip;
    logic [7:0] led;

    int vectors;
    int miscompares;

    // Reference model: architectural registers and LED value
    int m_reg [4];
    int m_led;

    mojo_top dut (
        .clk         (clk),
        .rst         (rst),
        .trainer_dip (trainer_dip),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = i;
        m_led = 0;
    endtask

    // Instruction semantics computed with plain integer arithmetic.
    task automatic model_exec(input logic [7:0] instr);
        int op, rd, rs, a, b, v;
        bit wr;
        op = int'(instr[7:4]);
        rd = int'(instr[3:2]);
        rs = int'(instr[1:0]);
        a  = m_reg[rd];
        b  = m_reg[rs];
        wr = 1'b1;
        v  = 0;
        case (op)
            1:  v = (a + b) % 256;
            2:  v = (a - b + 256) % 256;
            3:  v = a & b;
            4:  v = a | b;
            5:  v = a ^ b;
            6:  v = b;
            7:  v = 255 - b;
            8:  v = (a * 2) % 256;
            9:  v = a / 2;
            10: v = (a + 1) % 256;
            11: v = (a + 255) % 256;
            12: v = rs;
            13: v = 0;
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_reg[rd] = v;
            m_led     = v;
        end
    endtask

    // Called at a negedge just before a FETCH edge; returns at the
    // negedge after the WRITEBACK edge. When scramble is set the DIP
    // gets random values during DECODE/EXECUTE/WRITEBACK.
    task automatic exec_instr(input logic [7:0] instr, input bit scramble);
        trainer_dip = instr;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (scramble) trainer_dip = 8'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        model_exec(instr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trainer_dip = 8'h1E;
        #12;
        vectors++;
        if (led !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_led: got %02h want 00", led);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        // Three edges: LED must not change before WRITEBACK
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (led !== 8'h00) begin
                miscompares++;
                $display("FAIL pre_wb_led edge%0d: got %02h want 00", k + 1, led);
            end
        end
        @(posedge clk);
        @(negedge clk);
        model_exec(8'h1E);
        vectors++;
        if (led !== 8'h05) begin
            miscompares++;
            $display("FAIL first_add: got %02h want 05", led);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] want [2];
        want[0] = 8'h07;
        want[1] = 8'h09;
        for (int k = 0; k < 2; k++) begin
            exec_instr(8'h1E, 1'b0);
            vectors++;
            if (led !== want[k] || int'(led) !== m_led) begin
                miscompares++;
                $display("FAIL accumulate%0d: got %02h want %02h", k, led, want[k]);
            end
        end
    endtask

    task automatic test_sub_wrap();
        logic [7:0] want [5];
        logic [7:0] instr;
        want[0] = 8'h03; want[1] = 8'h02; want[2] = 8'h01;
        want[3] = 8'h00; want[4] = 8'hFF;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            instr = (k == 0) ? 8'h63 : 8'h21;
            exec_instr(instr, 1'b0);
            vectors++;
            if (led !== want[k] || int'(led) !== m_led) begin
                miscompares++;
                $display("FAIL sub_wrap%0d: got %02h want %02h", k, led, want[k]);
            end
        end
    endtask

    task automatic test_shl();
        logic [7:0] want;
        do_reset();
        exec_instr(8'hC6, 1'b0);
        vectors++;
        if (led !== 8'h02) begin
            miscompares++;
            $display("FAIL ldi: got %02h want 02", led);
        end
        want = 8'h02;
        for (int k = 0; k < 7; k++) begin
            want = {want[6:0], 1'b0};
            exec_instr(8'h85, 1'b0);
            vectors++;
            if (led !== want || int'(led) !== m_led) begin
                miscompares++;
                $display("FAIL shl%0d: got %02h want %02h", k, led, want);
            end
        end
    endtask

    task automatic test_nop();
        do_reset();
        exec_instr(8'h00, 1'b0);
        vectors++;
        if (led !== 8'h00) begin
            miscompares++;
            $display("FAIL nop_after_reset: got %02h want 00", led);
        end
        exec_instr(8'h4B, 1'b0);  // OR R2 <- R2|R3 = 03
        exec_instr(8'hF0, 1'b0);
        exec_instr(8'hE5, 1'b0);
        vectors++;
        if (led !== 8'h03 || int'(led) !== m_led) begin
            miscompares++;
            $display("FAIL reserved_hold: got %02h want 03", led);
        end
        // Register R2 must be untouched: MOV R0 <- R2
        exec_instr(8'h62, 1'b0);
        vectors++;
        if (led !== 8'h03) begin
            miscompares++;
            $display("FAIL nop_regs_kept: got %02h want 03", led);
        end
    endtask

    task automatic test_dip_toggle();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exec_instr(8'h1E, 1'b1);
            vectors++;
            if (int'(led) !== m_led) begin
                miscompares++;
                $display("FAIL dip_toggle%0d: got %02h want %02h", k, led, 8'(m_led));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        exec_instr(8'h1E, 1'b0);
        exec_instr(8'h1E, 1'b0);
        vectors++;
        if (led !== 8'h07) begin
            miscompares++;
            $display("FAIL pre_async: got %02h want 07", led);
        end
        trainer_dip = 8'h1E;
        @(posedge clk);  // FETCH
        @(posedge clk);  // DECODE, now in EXECUTE
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (led !== 8'h00) begin
            miscompares++;
            $display("FAIL async_led: got %02h want 00", led);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        exec_instr(8'h1E, 1'b0);
        vectors++;
        if (led !== 8'h05 || int'(led) !== m_led) begin
            miscompares++;
            $display("FAIL post_async: got %02h want 05", led);
        end
    endtask

    task automatic test_random();
        logic [7:0] instr;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            instr = 8'($urandom);
            exec_instr(instr, 1'b1);
            vectors++;
            if (int'(led) !== m_led) begin
                miscompares++;
                $display("FAIL random%0d instr=%02h: got %02h want %02h",
                         k, instr, led, 8'(m_led));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        trainer_dip = 8'h00;
        model_reset();
        test_reset();
        test_accumulate();
        test_sub_wrap();
        test_shl();
        test_nop();
        test_dip_toggle();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
